// File: rtl/score_ui_pkg.sv
// rtl/score_ui_pkg.sv - shared glyph geometry, colour type and blink state for the score UI
package score_ui_pkg;

   localparam int GLYPH_W     = 8;
   localparam int GLYPH_H     = 16;
   localparam int LABEL_SLOTS = 9;

   typedef logic [11:0] rgb444_t;

   typedef enum logic {
      IDLE  = 1'b0,
      BLINK = 1'b1
   } blink_state_t;

endpackage

// File: rtl/blink_ctrl.sv
// rtl/blink_ctrl.sv - frame-counted highlight blink episode controller
module blink_ctrl
   import score_ui_pkg::*;
#(
   parameter int BLINK_FRAMES = 60,
   parameter int BLINK_PERIOD = 8
) (
   input  logic clk,
   input  logic rst_n,
   input  logic frame_tick,
   input  logic highlight,
   output logic visible,
   output logic hl_active
);

   localparam int CNT_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
   localparam logic [CNT_W-1:0] LAST_FRAME = CNT_W'(BLINK_FRAMES - 1);

   blink_state_t     state;
   blink_state_t     state_next;
   logic [CNT_W-1:0] frame_cnt;
   logic [CNT_W-1:0] cnt_next;
   logic             phase_odd;

   // State and frame counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         frame_cnt <= '0;
      end else begin
         state     <= state_next;
         frame_cnt <= cnt_next;
      end
   end

   // Next-state logic; a highlight pulse always wins over a coincident frame tick
   always_comb begin
      state_next = state;
      cnt_next   = frame_cnt;
      visible    = 1'b1;
      hl_active  = 1'b0;
      phase_odd  = ((32'(frame_cnt) / 32'(BLINK_PERIOD)) % 32'd2) != 32'd0;
      case (state)
         IDLE: begin
            if (highlight) begin
               state_next = BLINK;
               cnt_next   = '0;
            end
         end
         BLINK: begin
            hl_active = 1'b1;
            visible   = ~phase_odd;
            if (highlight) begin
               cnt_next = '0;
            end else if (frame_tick) begin
               if (frame_cnt == LAST_FRAME) begin
                  state_next = IDLE;
                  cnt_next   = '0;
               end else begin
                  cnt_next = frame_cnt + 1'b1;
               end
            end
         end
         default: begin
            state_next = IDLE;
            cnt_next   = '0;
         end
      endcase
   end

endmodule

// File: rtl/score_label_renderer.sv
// rtl/score_label_renderer.sv - pixel-side renderer for the SCORE label glyph ROM
module score_label_renderer
   import score_ui_pkg::*;
#(
   parameter int      X0           = 64,
   parameter int      Y0           = 32,
   parameter rgb444_t FG_COLOR     = 12'hFFF,
   parameter rgb444_t HL_COLOR     = 12'hF00,
   parameter int      BLINK_FRAMES = 60,
   parameter int      BLINK_PERIOD = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [9:0]  pixel_x,
   input  logic [9:0]  pixel_y,
   input  logic        video_on,
   input  logic        frame_tick,
   input  logic        highlight,
   output logic [10:0] rom_addr,
   input  logic [7:0]  rom_data,
   output logic        text_on,
   output logic [11:0] text_rgb
);

   localparam logic [9:0] X0_V     = 10'(X0);
   localparam logic [9:0] Y0_V     = 10'(Y0);
   localparam logic [9:0] REGION_W = 10'(GLYPH_W * LABEL_SLOTS);
   localparam logic [9:0] REGION_H = 10'(GLYPH_H);

   logic [9:0] dx;
   logic [9:0] dy;
   logic [6:0] slot;
   logic       in_region;
   logic [2:0] bit_q;
   logic       hit_q;
   logic       glyph_bit;
   logic       text_on_next;
   rgb444_t    text_rgb_next;
   logic       visible;
   logic       hl_active;

   // Offsets wrap for pixels left of / above the origin, so the origin guard
   // keeps those from aliasing into the label box.
   assign dx        = pixel_x - X0_V;
   assign dy        = pixel_y - Y0_V;
   assign in_region = (pixel_x >= X0_V) && (dx < REGION_W) &&
                      (pixel_y >= Y0_V) && (dy < REGION_H);
   assign slot      = dx[9:3];
   assign rom_addr  = in_region ? {slot, dy[3:0]} : 11'h000;

   blink_ctrl #(
      .BLINK_FRAMES (BLINK_FRAMES),
      .BLINK_PERIOD (BLINK_PERIOD)
   ) u_blink (
      .clk        (clk),
      .rst_n      (rst_n),
      .frame_tick (frame_tick),
      .highlight  (highlight),
      .visible    (visible),
      .hl_active  (hl_active)
   );

   // Stage 1: carry bit position and hit flag alongside the ROM's address register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bit_q <= 3'd0;
         hit_q <= 1'b0;
      end else begin
         bit_q <= dx[2:0];
         hit_q <= in_region & video_on;
      end
   end

   // Glyph rows are MSB-first: column 0 of a glyph is rom_data[7]
   always_comb begin
      glyph_bit     = rom_data[3'd7 - bit_q];
      text_on_next  = hit_q & glyph_bit & visible;
      text_rgb_next = 12'h000;
      if (text_on_next) begin
         text_rgb_next = hl_active ? HL_COLOR : FG_COLOR;
      end
   end

   // Stage 2: registered pixel output to the video mux
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         text_on  <= 1'b0;
         text_rgb <= 12'h000;
      end else begin
         text_on  <= text_on_next;
         text_rgb <= text_rgb_next;
      end
   end

endmodule
